// File: rtl/ahb_burst_master_seq.sv
// AHB-Lite burst sequencer: one descriptor in, NONSEQ/SEQ/BUSY address phases out; first address one cycle after start_i.
// Address phase advances only on hready_i; stall_i inserts BUSY. AHB_BURST_BOUNDARY_SPLIT_EN splits INCR bursts at BOUND_BYTES.
module ahb_burst_master_seq #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int INCR_MAX    = 32,
  parameter int BOUND_BYTES = 1024
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        hburst_i,
  input  logic [2:0]        hsize_i,
  input  logic              hwrite_i,
  input  logic [5:0]        len_i,
  input  logic              stall_i,
  input  logic              hready_i,
  input  logic [1:0]        hresp_i,
  output logic [ADDR_W-1:0] haddr_o,
  output logic [1:0]        htrans_o,
  output logic [2:0]        hburst_o,
  output logic [2:0]        hsize_o,
  output logic              hwrite_o,
  output logic              busy_o,
  output logic [5:0]        beat_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR   = 3'd1;
  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NSEQ   = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;
  localparam logic [2:0] SIZE_MAX  = 3'($clog2(DATA_W / 8));
  localparam logic [6:0] BEATS_MAX = 7'(INCR_MAX);
  localparam logic [ADDR_W-1:0] BOUND_M = ADDR_W'(BOUND_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] haddr_n;
  logic [1:0]        htrans_n;
  logic [2:0]        hburst_n, hsize_n;
  logic              hwrite_n;
  logic [5:0]        beat_n;
  logic [6:0]        nbeats, nbeats_n, cnt, cnt_n;
  logic              dvld, dvld_n, err_q, err_n;

  logic [6:0]        req_beats;
  logic [7:0]        req_bytes;
  logic [31:0]       req_span, req_off;
  logic              size_bad, align_bad, len_bad, cross_bad, reject;

  logic [ADDR_W-1:0] bytes, wmask, addr_inc, addr_nxt;
  logic              wrap, split_nxt, split_cur;

  always_comb begin
    case (hburst_i)
      3'd0:       req_beats = 7'd1;
      3'd1:       req_beats = (len_i == 6'd0) ? BEATS_MAX : {1'b0, len_i};
      3'd2, 3'd3: req_beats = 7'd4;
      3'd4, 3'd5: req_beats = 7'd8;
      default:    req_beats = 7'd16;
    endcase
    req_bytes = 8'd1 << hsize_i;
    req_span  = 32'(req_beats) * 32'(req_bytes);
    req_off   = 32'(addr_i & BOUND_M);
    size_bad  = hsize_i > SIZE_MAX;
    align_bad = |(addr_i & (ADDR_W'(req_bytes) - ADDR_W'(1)));
    len_bad   = (hburst_i == B_INCR) && ({1'b0, len_i} > BEATS_MAX);
`ifdef AHB_BURST_BOUNDARY_SPLIT_EN
    cross_bad = hburst_i[0] && (hburst_i != B_INCR) && (req_off + req_span > 32'(BOUND_BYTES));
`else
    cross_bad = hburst_i[0] && (req_off + req_span > 32'(BOUND_BYTES));
`endif
    reject = size_bad | align_bad | len_bad | cross_bad;
  end

  // WRAP keeps the upper bits of the beats*bytes window and wraps only the low bits.
  always_comb begin
    bytes    = ADDR_W'(1) << hsize_o;
    wmask    = (ADDR_W'(nbeats) << hsize_o) - ADDR_W'(1);
    addr_inc = haddr_o + bytes;
    wrap     = !hburst_o[0] && (hburst_o != B_SINGLE);
    addr_nxt = wrap ? ((haddr_o & ~wmask) | (addr_inc & wmask)) : addr_inc;
`ifdef AHB_BURST_BOUNDARY_SPLIT_EN
    split_nxt = (hburst_o == B_INCR) && ((addr_nxt & BOUND_M) == '0);
    split_cur = (hburst_o == B_INCR) && ((haddr_o & BOUND_M) == '0);
`else
    split_nxt = 1'b0;
    split_cur = 1'b0;
`endif
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    haddr_n  = haddr_o;
    htrans_n = htrans_o;
    hburst_n = hburst_o;
    hsize_n  = hsize_o;
    hwrite_n = hwrite_o;
    nbeats_n = nbeats;
    cnt_n    = cnt;
    beat_n   = beat_o;
    dvld_n   = dvld;
    err_n    = err_q;
    // dvld marks a data phase that belongs to a NONSEQ/SEQ transfer
    if (hready_i) begin
      if (dvld) beat_n = beat_o + 6'd1;
      dvld_n = htrans_o[1];
    end
    case (state)
      S_IDLE: begin
        if (start_i) begin
          beat_n = 6'd0;
          dvld_n = 1'b0;
          err_n  = reject;
          if (reject) begin
            state_n = S_DONE;
          end else begin
            state_n  = S_ADDR;
            haddr_n  = addr_i;
            htrans_n = T_NSEQ;
            hburst_n = hburst_i;
            hsize_n  = hsize_i;
            hwrite_n = hwrite_i;
            nbeats_n = req_beats;
            cnt_n    = 7'd0;
          end
        end
      end
      S_ADDR: begin
        if (!hready_i && hresp_i != 2'd0) begin
          htrans_n = T_IDLE;
          err_n    = 1'b1;
          state_n  = S_LAST;
        end else if (hready_i) begin
          if (htrans_o == T_BUSY) begin
            if (!stall_i) htrans_n = split_cur ? T_NSEQ : T_SEQ;
          end else if (cnt + 7'd1 == nbeats) begin
            cnt_n    = cnt + 7'd1;
            htrans_n = T_IDLE;
            state_n  = S_LAST;
          end else begin
            cnt_n    = cnt + 7'd1;
            haddr_n  = addr_nxt;
            htrans_n = stall_i ? T_BUSY : (split_nxt ? T_NSEQ : T_SEQ);
          end
        end
      end
      S_LAST: begin
        if (hready_i)                  state_n = S_DONE;
        else if (hresp_i != 2'd0)      err_n   = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr_o  <= '0;
      htrans_o <= T_IDLE;
      hburst_o <= B_SINGLE;
      hsize_o  <= 3'd0;
      hwrite_o <= 1'b0;
      beat_o   <= 6'd0;
      nbeats   <= 7'd0;
      cnt      <= 7'd0;
      dvld     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      haddr_o  <= haddr_n;
      htrans_o <= htrans_n;
      hburst_o <= hburst_n;
      hsize_o  <= hsize_n;
      hwrite_o <= hwrite_n;
      beat_o   <= beat_n;
      nbeats   <= nbeats_n;
      cnt      <= cnt_n;
      dvld     <= dvld_n;
      err_q    <= err_n;
    end
  end

  assign busy_o = (state == S_ADDR) || (state == S_LAST);
  assign done_o = (state == S_DONE);
  assign err_o  = done_o && err_q;

endmodule

// File: tb/tb_ahb_burst_master_seq.sv
// Random and directed bursts against a transaction-level model of the burst sequencer.
module tb_ahb_burst_master_seq;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_BUSY = 2'd1;
  localparam logic [1:0] T_NSEQ = 2'd2;
  localparam logic [1:0] T_SEQ  = 2'd3;
`ifdef AHB_BURST_BOUNDARY_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [2:0]  hburst_i = '0;
  logic [2:0]  hsize_i = '0;
  logic        hwrite_i = 1'b0;
  logic [5:0]  len_i = '0;
  logic        stall_i = 1'b0;
  logic        hready_i = 1'b1;
  logic [1:0]  hresp_i = '0;
  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic [2:0]  hburst_o, hsize_o;
  logic        hwrite_o, busy_o, done_o, err_o;
  logic [5:0]  beat_o;

  int checks = 0;
  int errors = 0;

  ahb_burst_master_seq dut (
    .hclk(hclk), .hresetn(hresetn), .start_i(start_i), .addr_i(addr_i),
    .hburst_i(hburst_i), .hsize_i(hsize_i), .hwrite_i(hwrite_i), .len_i(len_i),
    .stall_i(stall_i), .hready_i(hready_i), .hresp_i(hresp_i),
    .haddr_o(haddr_o), .htrans_o(htrans_o), .hburst_o(hburst_o), .hsize_o(hsize_o),
    .hwrite_o(hwrite_o), .busy_o(busy_o), .beat_o(beat_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 hclk = ~hclk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_burst(input logic [31:0] a, input logic [2:0] hb, input logic [2:0] hs,
                           input logic hw, input logic [5:0] ln, input int err_sel,
                           input int hr_pct, input int st_pct, input int lo_beat, input int st_beat);
    int nb, bytes, span, eb, issued, completed, dphase, lo_cnt, cyc, err_state;
    bit rej, aborted, finished, lp, hr, st, exp_done;
    logic [1:0]  rsp, ecode, exp_t;
    logic [31:0] exp_a, ad;
    logic [31:0] addrs[$];
    logic [1:0]  kinds[$];

    case (hb)
      3'd0:       nb = 1;
      3'd1:       nb = (ln == 6'd0) ? 32 : int'(ln);
      3'd2, 3'd3: nb = 4;
      3'd4, 3'd5: nb = 8;
      default:    nb = 16;
    endcase
    bytes = 1 << hs;
    span  = nb * bytes;
    rej = (bytes > 4) || (a % bytes != 0) || (hb == 3'd1 && ln > 6'd32);
    if (hb[0] && !(SPLIT && hb == 3'd1) && (a % 1024) + span > 1024) rej = 1'b1;
    for (int i = 0; i < nb; i++) begin
      if (hb != 3'd0 && !hb[0]) ad = a - (a % span) + ((a % span) + i * bytes) % span;
      else                      ad = a + i * bytes;
      addrs.push_back(ad);
      kinds.push_back((i == 0 || (SPLIT && hb == 3'd1 && ad % 1024 == 0)) ? T_NSEQ : T_SEQ);
    end

    @(negedge hclk);
    start_i = 1'b1; addr_i = a; hburst_i = hb; hsize_i = hs; hwrite_i = hw; len_i = ln;
    hready_i = 1'b1; stall_i = 1'b0; hresp_i = 2'd0;
    @(negedge hclk);
    start_i = 1'b0;
    if (rej) begin
      check_eq("rej_done", done_o, 1);
      check_eq("rej_err", err_o, 1);
      check_eq("rej_busy", busy_o, 0);
      check_eq("rej_htrans", htrans_o, T_IDLE);
    end else begin
      check_eq("start_busy", busy_o, 1);
      check_eq("start_htrans", htrans_o, T_NSEQ);
      check_eq("start_haddr", haddr_o, a);
      check_eq("start_hburst", hburst_o, hb);
      check_eq("start_hsize", hsize_o, hs);
      check_eq("start_hwrite", hwrite_o, hw);
      check_eq("start_beat", beat_o, 0);
      exp_t = T_NSEQ; exp_a = a; issued = 0; completed = 0; dphase = -1;
      aborted = 1'b0; finished = 1'b0; err_state = 0; lo_cnt = 0; cyc = 0;
      eb = (err_sel >= 0) ? err_sel % nb : -1;
      ecode = 2'($urandom_range(1, 3));
      while (!finished && cyc < 3000) begin
        hr  = int'($urandom_range(0, 99)) < hr_pct;
        st  = int'($urandom_range(0, 99)) < st_pct;
        rsp = 2'd0;
        if (issued == st_beat && exp_t != T_BUSY) st = 1'b1;
        if (issued == lo_beat && lo_cnt < 2) begin hr = 1'b0; lo_cnt++; end
        if (err_state == 1) begin
          hr = 1'b1; rsp = ecode; err_state = 2;
        end else if (err_state == 0 && eb >= 0 && dphase == eb) begin
          hr = 1'b0; rsp = ecode; err_state = 1;
        end
        lp = (issued == nb) || aborted;
        start_i  = ($urandom_range(0, 7) == 0);
        addr_i   = $urandom;
        hburst_i = 3'($urandom_range(0, 7));
        hready_i = hr; stall_i = st; hresp_i = rsp;
        @(negedge hclk);
        cyc++;
        exp_done = lp && hr;
        if (rsp != 2'd0 && !hr) aborted = 1'b1;
        if (hr) begin
          if (dphase >= 0) completed++;
          if (exp_t[1]) begin dphase = issued; issued++; end
          else dphase = -1;
        end
        if (!exp_done) begin
          if (aborted) exp_t = T_IDLE;
          else if (hr) begin
            if (issued == nb) exp_t = T_IDLE;
            else begin
              exp_a = addrs[issued];
              exp_t = st ? T_BUSY : kinds[issued];
            end
          end
        end
        check_eq("done", done_o, exp_done);
        if (exp_done) begin
          finished = 1'b1;
          check_eq("done_err", err_o, aborted);
          check_eq("done_busy", busy_o, 0);
          check_eq("done_htrans", htrans_o, T_IDLE);
          check_eq("done_beat", beat_o, completed);
        end else begin
          check_eq("busy", busy_o, 1);
          check_eq("htrans", htrans_o, exp_t);
          if (exp_t != T_IDLE) check_eq("haddr", haddr_o, exp_a);
          check_eq("beat", beat_o, completed);
        end
      end
      check_eq("timeout", finished, 1);
    end
    // a start during the completion cycle must not launch a burst
    start_i = 1'b1; addr_i = 32'h100; hburst_i = 3'd3; hsize_i = 3'd2; len_i = 6'd0;
    hready_i = 1'b1; stall_i = 1'b0; hresp_i = 2'd0;
    @(negedge hclk);
    start_i = 1'b0;
    check_eq("ign_busy", busy_o, 0);
    check_eq("ign_htrans", htrans_o, T_IDLE);
    check_eq("ign_done", done_o, 0);
  endtask

  initial begin
    #12;
    check_eq("rst_haddr", haddr_o, 0);
    check_eq("rst_htrans", htrans_o, T_IDLE);
    check_eq("rst_hburst", hburst_o, 0);
    check_eq("rst_hsize", hsize_o, 0);
    check_eq("rst_hwrite", hwrite_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_beat", beat_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_err", err_o, 0);
    @(negedge hclk);
    hresetn = 1'b1;

    run_burst(32'h100, 3'd3, 3'd2, 1'b1, 6'd0, -1, 100, 0, -1, -1);
    run_burst(32'h038, 3'd2, 3'd2, 1'b0, 6'd0, -1, 100, 0, -1, -1);
    run_burst(32'h00E, 3'd4, 3'd1, 1'b1, 6'd0, -1, 100, 0, 2, -1);
    run_burst(32'h3FE, 3'd1, 3'd0, 1'b0, 6'd3, -1, 100, 0, -1, 1);
    run_burst(32'h200, 3'd5, 3'd2, 1'b0, 6'd0, 2, 100, 0, -1, -1);
    run_burst(32'h100, 3'd3, 3'd3, 1'b0, 6'd0, -1, 100, 0, -1, -1);
    run_burst(32'h102, 3'd0, 3'd2, 1'b0, 6'd0, -1, 100, 0, -1, -1);
    run_burst(32'h000, 3'd1, 3'd2, 1'b1, 6'd40, -1, 100, 0, -1, -1);
    run_burst(32'h000, 3'd1, 3'd2, 1'b1, 6'd0, -1, 80, 20, -1, -1);
    run_burst(32'h3C0, 3'd7, 3'd2, 1'b0, 6'd0, -1, 100, 0, -1, -1);
    run_burst(32'h3C4, 3'd7, 3'd2, 1'b0, 6'd0, -1, 100, 0, -1, -1);

    // asynchronous reset in the middle of a burst
    @(negedge hclk);
    start_i = 1'b1; addr_i = 32'h200; hburst_i = 3'd7; hsize_i = 3'd2; len_i = 6'd0;
    hready_i = 1'b1; stall_i = 1'b0; hresp_i = 2'd0;
    @(negedge hclk);
    start_i = 1'b0;
    repeat (3) @(negedge hclk);
    check_eq("mid_busy", busy_o, 1);
    #2 hresetn = 1'b0;
    #1;
    check_eq("arst_htrans", htrans_o, T_IDLE);
    check_eq("arst_haddr", haddr_o, 0);
    check_eq("arst_busy", busy_o, 0);
    check_eq("arst_hburst", hburst_o, 0);
    check_eq("arst_beat", beat_o, 0);
    @(negedge hclk);
    hresetn = 1'b1;

    for (int n = 0; n < 40; n++) begin
      logic [2:0]  hb, hs;
      logic [31:0] a;
      logic [5:0]  ln;
      hb = 3'($urandom_range(0, 7));
      hs = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      ln = 6'($urandom_range(0, 36));
      a  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 2047)) : 32'(1024 - $urandom_range(1, 64));
      if ($urandom_range(0, 5) != 0) a = a & ~((32'd1 << hs) - 32'd1);
      run_burst(a, hb, hs, 1'($urandom_range(0, 1)), ln,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1,
                int'($urandom_range(50, 100)), int'($urandom_range(0, 40)), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_burst_master_seq.md
Name: ahb_burst_master_seq

Overview:
- Master-side AHB-Lite burst sequencer sitting between a local request port and the AHB address/control bus.
- Accepts one burst descriptor per request: start address, HBURST, HSIZE, HWRITE and, for INCR, a beat count.
- Drives HADDR/HTRANS/HBURST/HSIZE/HWRITE cycle by cycle and generates INCR and WRAP addresses.
- Inserts BUSY on local stall, aborts on ERROR, and reports completion. Data path is outside this block; it uses beat_o.

Parameters:
ADDR_W, 32, address width (bits)
DATA_W, 32, bus data width; max legal transfer size is DATA_W/8 bytes
INCR_MAX, 32, beat count used for INCR when len_i==0; also the upper bound on len_i
BOUND_BYTES, 1024, AHB address boundary that a burst must not cross

Ports:
hclk  in  1  bus clock, rising edge
hresetn  in  1  asynchronous active-low reset
start_i  in  1  request strobe; accepted only when busy_o==0
addr_i  in  ADDR_W  burst start address
hburst_i  in  3  SINGLE,INCR,WRAP4,INCR4,WRAP8,INCR8,WRAP16,INCR16 encoding 0..7
hsize_i  in  3  BYTE..TWORD encoding 0..7
hwrite_i  in  1  0=READ, 1=WRITE
len_i  in  6  INCR beat count, 1..INCR_MAX; 0 means INCR_MAX; ignored for other bursts
stall_i  in  1  local not-ready; requests BUSY insertion
hready_i  in  1  AHB HREADY
hresp_i  in  2  OKAY,ERROR,RETRY,SPLIT encoding 0..3
haddr_o  out  ADDR_W  HADDR
htrans_o  out  2  IDLE,BUSY,NONSEQ,SEQ encoding 0..3
hburst_o, hsize_o, hwrite_o  out  3,3,1  registered copies of the accepted descriptor
busy_o  out  1  burst in progress
beat_o  out  6  index of the current data-phase beat, 0-based
done_o  out  1  one-cycle completion pulse
err_o  out  1  qualifies done_o: 1 = rejected or aborted

Behaviour:
- Reset: haddr_o=0, htrans_o=IDLE, hburst_o=SINGLE, hsize_o=BYTE, hwrite_o=0, busy_o=0, beat_o=0, done_o=0, err_o=0.
- Beats per burst:
  - SINGLE=1; WRAP4/INCR4=4; WRAP8/INCR8=8; WRAP16/INCR16=16.
  - INCR=len_i, with 0 meaning INCR_MAX.
  - bytes per beat = 1<<hsize_i.
- Descriptor rejection. A descriptor is rejected if any of these holds:
  - (1<<hsize_i) > DATA_W/8;
  - addr_i is not aligned to the transfer size;
  - a non-INCR incrementing burst crosses BOUND_BYTES;
  - len_i > INCR_MAX.
- On rejection: no bus activity; the cycle after start_i, done_o=1 and err_o=1.
- States: IDLE, ADDR (NONSEQ/SEQ/BUSY issued), LAST_DATA, DONE.
  - IDLE: on accepted start_i, the next cycle has busy_o=1, htrans_o=NONSEQ, haddr_o=addr_i.
  - ADDR: the address phase advances only on hready_i=1. When hready_i=0, all address/control outputs hold.
    - Each advance increments the issued-beat count.
    - Next address, INCR*: addr + bytes.
    - Next address, WRAP*: (addr & ~M) | ((addr + bytes) & M), with M = beats*bytes - 1.
    - Next htrans is SEQ, or BUSY if stall_i=1 at the advance. BUSY is never issued before the first beat or after the last beat.
    - During BUSY, haddr_o already holds the next address; SEQ resumes on the first hready_i=1 edge with stall_i=0.
    - After the last beat advances: htrans_o=IDLE, go to LAST_DATA.
  - LAST_DATA: wait for hready_i=1, then go to DONE.
  - DONE: done_o=1, err_o=0 for one cycle; busy_o=0 in the same cycle; return to IDLE. A start_i in the DONE cycle is ignored.
- beat_o increments on each hready_i=1 data-phase completion of a non-BUSY transfer; it resets to 0 at start.
- ERROR handling: hresp_i=ERROR with hready_i=0 in any busy state →
  - next cycle htrans_o=IDLE;
  - remaining beats are cancelled;
  - on the following hready_i=1, done_o=1 and err_o=1.
- RETRY and SPLIT are treated as ERROR.
- start_i while busy_o=1 is ignored with no side effects.
- hresetn asserted mid-burst: all outputs return to reset values immediately (asynchronous); the burst is lost.

Optional Feature:
- Macro: AHB_BURST_BOUNDARY_SPLIT_EN.
- Defined: an INCR burst that would cross BOUND_BYTES is split at the boundary. The first beat above the boundary is issued as NONSEQ instead of SEQ, and the beat count continues without gaps.
- Undefined: such an INCR descriptor is rejected (done_o=1, err_o=1, no bus activity).

Test Plan:
- INCR4, WORD, addr 0x100, hready always 1 → haddr 0x100,0x104,0x108,0x10C; htrans NONSEQ,SEQ,SEQ,SEQ,IDLE; done_o 1 cycle later with err_o=0.
- WRAP4, WORD, addr 0x38 → haddr 0x38,0x3C,0x30,0x34; beat_o 0..3.
- WRAP8, HWORD, addr 0x0E, hready low 2 cycles at beat 2 → addresses 0x0E,0x00,0x02,...,0x0C; outputs held while hready low.
- INCR, len 3, BYTE, addr 0x3FE with stall_i at beat 1 → 0x3FE NONSEQ, 0x3FF SEQ, BUSY holding 0x400, then 0x400. With the macro defined, the 0x400 beat is NONSEQ. With it undefined, the descriptor is rejected: err_o=1, htrans stays IDLE.
- INCR8, WORD, hresp ERROR (hready low) on beat 2 → htrans IDLE next cycle, no beat 3 issued, done_o=1 with err_o=1.
- hsize=DWORD with DATA_W=32, or addr 0x102 with WORD → done_o=1, err_o=1 one cycle after start; htrans never leaves IDLE.
